// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port byte-writable RAM.
// Clear-sequencer states and data-width legality check.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

  function automatic int nbytes(input int dw);
    return dw / 8;
  endfunction

  function automatic bit width_ok(input int dw);
    return (dw % 8) == 0;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset zero-fill sequencer: walks every word once, then raises oReady.
// Instantiated only when RAM_CLEAR_EN is defined.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDRWIDTH = 9
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  output logic                 oReady,
  output logic                 clr_we,
  output logic [ADDRWIDTH-1:0] clr_addr
);

  localparam int MEMDEPTH = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] LAST =
    (ADDRWIDTH+1)'(MEMDEPTH - 1);

  clr_state_t           state;
  logic [ADDRWIDTH:0]   cnt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state  <= CLEAR;
      cnt    <= '0;
      oReady <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= READY;
            oReady <= 1'b1;
          end
        end
        READY: oReady <= 1'b1;
        default: begin
          state  <= CLEAR;
          oReady <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = cnt[ADDRWIDTH-1:0];

endmodule

// File: rtl/ram_dp_be.sv
// Dual-port RAM: port A fetch (read-only), port B data (byte-enabled R/W).
// Define RAM_CLEAR_EN to zero-fill the array after every reset.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int ADDRWIDTH = 9,
  parameter int DATAWIDTH = 32
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  output logic                   oReady,
  input  logic                   iA_En,
  input  logic [ADDRWIDTH-1:0]   iA_Address,
  output logic [DATAWIDTH-1:0]   oA_ReadData,
  output logic                   oA_Valid,
  input  logic                   iB_En,
  input  logic                   iB_WR,
  input  logic [DATAWIDTH/8-1:0] iB_ByteEn,
  input  logic [ADDRWIDTH-1:0]   iB_Address,
  input  logic [DATAWIDTH-1:0]   iB_WriteData,
  output logic [DATAWIDTH-1:0]   oB_ReadData,
  output logic                   oB_Valid
);

  localparam int MEMDEPTH = 1 << ADDRWIDTH;
  localparam int NBYTES   = nbytes(DATAWIDTH);

  if (!width_ok(DATAWIDTH)) begin : g_bad_width
    $error("DATAWIDTH must be a multiple of 8");
  end

  logic                 ready;
  logic                 clr_we;
  logic [ADDRWIDTH-1:0] clr_addr;

`ifdef RAM_CLEAR_EN
  ram_clear_seq #(
    .ADDRWIDTH (ADDRWIDTH)
  ) u_clear (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .oReady   (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );
`else
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) ready <= 1'b0;
    else         ready <= 1'b1;
  end

  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  assign oReady = ready;

  logic a_go;
  logic b_go;
  logic b_wr;

  assign a_go = ready & iA_En;
  assign b_go = ready & iB_En;
  assign b_wr = b_go & iB_WR;

  logic [ADDRWIDTH-1:0] a_addr;
  logic [ADDRWIDTH-1:0] b_addr;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      a_addr   <= '0;
      b_addr   <= '0;
      oA_Valid <= 1'b0;
      oB_Valid <= 1'b0;
    end else begin
      oA_Valid <= a_go;
      oB_Valid <= b_go & ~iB_WR;
      if (a_go) a_addr <= iA_Address;
      if (b_go) b_addr <= iB_Address;
    end
  end

  // Clear and port-B writes never overlap: clear runs only while not ready.
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [DATAWIDTH-1:0] wr_data;

  assign wr_addr = clr_we ? clr_addr : iB_Address;
  assign wr_data = clr_we ? '0 : iB_WriteData;

  logic [DATAWIDTH-1:0] a_word;
  logic [DATAWIDTH-1:0] b_word;

  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    logic [7:0] lane [MEMDEPTH];
    logic       we;

    assign we = clr_we | (b_wr & iB_ByteEn[i]);

    always_ff @(posedge iClk) begin
      if (we) lane[wr_addr] <= wr_data[8*i +: 8];
    end

    assign a_word[8*i +: 8] = lane[a_addr];
    assign b_word[8*i +: 8] = lane[b_addr];
  end

  assign oA_ReadData = ready ? a_word : '0;
  assign oB_ReadData = ready ? b_word : '0;

endmodule
